rgb_fade_sequencer: RTL and testbench
=====================================

# rgb_fade_sequencer

Autonomous colour sequencer that supplies the 8-bit red/green/blue duty-cycle inputs of the on-board RGB PWM controller. Holds a small programmable palette, loaded from switches or the host side. While enabled, it steps through the palette in a loop. Each transition is a linear fade at a programmable rate, followed by a programmable hold at the target colour.

## Interface
- STEP_DIV, 50000: clock cycles per fade tick (≥2)
- HOLD_TICKS, 500: fade ticks spent holding each palette colour (≥1)
- NUM_COLORS, 4: palette entries, power of two, 2..16
- IDX_W, 2: log2(NUM_COLORS)

- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- en_in  input  1  run enable; low freezes outputs and returns to IDLE
- wr_en_in  input  1  palette write strobe, single cycle
- wr_addr_in  input  IDX_W  palette entry to write
- wr_rgb_in  input  24  {r[23:16], g[15:8], b[7:0]} write data
- r_out, g_out, b_out  output  8 each  duty cycles to PWM controller (registered)
- idx_out  output  IDX_W  current target palette index
- busy_out  output  1  high when state ≠ IDLE
- wrap_out  output  1  one-cycle pulse when idx advances from NUM_COLORS-1 to 0

## Operation
- Reset (rst_in low at a clk_in edge): state IDLE, r/g/b_out = 0, idx_out = 0, busy_out = 0, wrap_out = 0, prescaler = 0, hold counter = 0, all palette entries = 0.
- Palette: NUM_COLORS × 24-bit registers. A write with wr_en_in high is accepted in any state and is visible at the next edge. The target is always read live from palette[idx_out], so rewriting the current target re-targets an in-progress fade.
- Prescaler: counts 0..STEP_DIV-1 while state ≠ IDLE. "tick" = prescaler == STEP_DIV-1, and the prescaler wraps to 0 on that edge. The prescaler is forced to 0 in IDLE.
- States:
  - IDLE: en_in high → FADE (prescaler 0, outputs unchanged).
  - FADE: on each tick, each channel independently moves ±1 toward its target channel, or stays if already equal. If all three post-step values equal the target, go to HOLD with hold counter 0. A tick with all channels already equal goes to HOLD with no change.
  - HOLD: on each tick, hold counter +1. On the tick where the counter == HOLD_TICKS-1, idx_out increments modulo NUM_COLORS, the counter clears, and the state returns to FADE. wrap_out pulses if the new idx is 0.
  - en_in low in any state → IDLE at the next edge. Outputs and idx_out are held, and the prescaler and hold counter clear. Re-enable resumes fading toward palette[idx_out].
- Arithmetic: channels are unsigned 8-bit and step by exactly 1, so they never overshoot, overflow or underflow.
- Priority at an edge: reset > en_in low > tick logic. A palette write coincident with a tick does not affect that tick's compare. The tick uses the pre-write value, and the new value applies from the next tick.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- First output change occurs STEP_DIV edges after the edge that enters FADE.
- Fade duration for a channel delta D (largest of the three) = D ticks = D·STEP_DIV cycles. HOLD is entered on the same tick as the last step.
- Hold duration = HOLD_TICKS ticks. idx_out changes on the edge of the final hold tick, and FADE stepping toward the new target begins on the next tick.
- busy_out = 1 from the edge entering FADE until the edge entering IDLE.
- wrap_out is high for exactly one clk_in cycle.

## Test plan
(STEP_DIV=2, HOLD_TICKS=3, NUM_COLORS=4 unless stated)
- Reset: drive rst_in low for 2 cycles with en_in high → all outputs 0, busy_out 0, idx_out 0, and all palette entries read back as targets of 0.
- Single fade: palette[0]=0x030100, enable → r_out steps 1,2,3 and g_out steps 1 at cycles 2,4,6; HOLD is entered at cycle 6; idx_out becomes 1 at cycle 12.
- Loop/wrap: palette = {0x000005, 0x000000, 0x000005, 0x000000} → b_out ramps up and down repeatedly; wrap_out pulses once per full cycle, aligned with idx_out 3→0.
- Disable mid-fade: palette[0]=0xFF0000, drop en_in after r_out=10 → r_out stays 10 and busy_out=0 next cycle; re-enable → r_out=11 two cycles later.
- Retarget: during a fade toward r=200 at r_out=50, write palette[idx]=0x1E0000 → r_out decreases to 30, then HOLD.
- Reset mid-HOLD: assert rst_in in HOLD with idx_out=2 → next edge all outputs 0, idx_out 0, state IDLE, palette cleared.

Source files
------------

// File: rtl/rgb_fade_sequencer.sv
// Autonomous RGB colour sequencer: walks a small palette in a loop. Each step is a
// linear per-channel fade followed by a hold at the target colour.
module rgb_fade_sequencer #(
    parameter int STEP_DIV   = 50000,
    parameter int HOLD_TICKS = 500,
    parameter int NUM_COLORS = 4,
    parameter int IDX_W      = 2
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic             wr_en_in,
    input  logic [IDX_W-1:0] wr_addr_in,
    input  logic [23:0]      wr_rgb_in,
    output logic [7:0]       r_out,
    output logic [7:0]       g_out,
    output logic [7:0]       b_out,
    output logic [IDX_W-1:0] idx_out,
    output logic             busy_out,
    output logic             wrap_out,
    output logic [1:0]       state_out
);

    localparam int PRE_W  = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FADE = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    logic [PRE_W-1:0]    r_presc;
    logic [HOLD_W-1:0]   r_hold;
    logic [7:0]          r_r;
    logic [7:0]          r_g;
    logic [7:0]          r_b;
    logic [IDX_W-1:0]    r_idx;
    logic                r_wrap;
    logic [23:0]         r_pal [NUM_COLORS];

    state_t              w_state_nxt;
    logic [PRE_W-1:0]    w_presc_nxt;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic [7:0]          w_r_nxt;
    logic [7:0]          w_g_nxt;
    logic [7:0]          w_b_nxt;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic                w_wrap_nxt;

    logic [23:0]         w_target;
    logic [7:0]          w_step_r;
    logic [7:0]          w_step_g;
    logic [7:0]          w_step_b;
    logic                w_tick;
    logic [IDX_W-1:0]    w_idx_inc;

    function automatic logic [7:0] step8(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt)      return cur + 8'd1;
        else if (cur > tgt) return cur - 8'd1;
        else                return cur;
    endfunction

    // Target is read from the registered palette, so a write landing on a tick
    // edge only influences the following tick.
    assign w_target  = r_pal[r_idx];
    assign w_step_r  = step8(r_r, w_target[23:16]);
    assign w_step_g  = step8(r_g, w_target[15:8]);
    assign w_step_b  = step8(r_b, w_target[7:0]);
    assign w_tick    = (r_state != ST_IDLE) && (r_presc == PRE_LAST);
    assign w_idx_inc = r_idx + IDX_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_hold_nxt  = r_hold;
        w_r_nxt     = r_r;
        w_g_nxt     = r_g;
        w_b_nxt     = r_b;
        w_idx_nxt   = r_idx;
        w_wrap_nxt  = 1'b0;

        if (!en_in) begin
            w_state_nxt = ST_IDLE;
            w_presc_nxt = '0;
            w_hold_nxt  = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FADE;
                    w_presc_nxt = '0;
                end
                ST_FADE: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + PRE_W'(1);
                    if (w_tick) begin
                        w_r_nxt = w_step_r;
                        w_g_nxt = w_step_g;
                        w_b_nxt = w_step_b;
                        if ({w_step_r, w_step_g, w_step_b} == w_target) begin
                            w_state_nxt = ST_HOLD;
                            w_hold_nxt  = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    w_presc_nxt = w_tick ? '0 : r_presc + PRE_W'(1);
                    if (w_tick) begin
                        if (r_hold == HOLD_LAST) begin
                            w_idx_nxt   = w_idx_inc;
                            w_hold_nxt  = '0;
                            w_state_nxt = ST_FADE;
                            w_wrap_nxt  = (w_idx_inc == '0);
                        end else begin
                            w_hold_nxt = r_hold + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_presc_nxt = '0;
                    w_hold_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_hold  <= '0;
            r_r     <= '0;
            r_g     <= '0;
            r_b     <= '0;
            r_idx   <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_hold  <= w_hold_nxt;
            r_r     <= w_r_nxt;
            r_g     <= w_g_nxt;
            r_b     <= w_b_nxt;
            r_idx   <= w_idx_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    // wr_en_in is a single-cycle strobe with no back-pressure: always accepted.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_COLORS; i++) begin
                r_pal[i] <= '0;
            end
        end else if (wr_en_in) begin
            r_pal[wr_addr_in] <= wr_rgb_in;
        end
    end

    assign r_out     = r_r;
    assign g_out     = r_g;
    assign b_out     = r_b;
    assign idx_out   = r_idx;
    assign wrap_out  = r_wrap;
    assign busy_out  = (r_state != ST_IDLE);
    assign state_out = r_state;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed bench for rgb_fade_sequencer with STEP_DIV=2, HOLD_TICKS=3, NUM_COLORS=4.
module tb_rgb_fade_sequencer;

    localparam int STEP_DIV   = 2;
    localparam int HOLD_TICKS = 3;
    localparam int NUM_COLORS = 4;
    localparam int IDX_W      = 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FADE = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic             en_in;
    logic             wr_en_in;
    logic [IDX_W-1:0] wr_addr_in;
    logic [23:0]      wr_rgb_in;
    logic [7:0]       r_out;
    logic [7:0]       g_out;
    logic [7:0]       b_out;
    logic [IDX_W-1:0] idx_out;
    logic             busy_out;
    logic             wrap_out;
    logic [1:0]       state_out;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    int         wrap_q[$];

    always #5 clk_in = ~clk_in;

    rgb_fade_sequencer #(
        .STEP_DIV  (STEP_DIV),
        .HOLD_TICKS(HOLD_TICKS),
        .NUM_COLORS(NUM_COLORS),
        .IDX_W     (IDX_W)
    ) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en_in     (en_in),
        .wr_en_in  (wr_en_in),
        .wr_addr_in(wr_addr_in),
        .wr_rgb_in (wr_rgb_in),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out),
        .idx_out   (idx_out),
        .busy_out  (busy_out),
        .wrap_out  (wrap_out),
        .state_out (state_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_in   = 1'b0;
        en_in    = 1'b0;
        wr_en_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
    endtask

    task automatic wr_pal(input logic [IDX_W-1:0] addr, input logic [23:0] rgb);
        wr_en_in   = 1'b1;
        wr_addr_in = addr;
        wr_rgb_in  = rgb;
        @(negedge clk_in);
        wr_en_in = 1'b0;
    endtask

    initial begin
        int n_wrap;
        int wrap_k;
        int nonzero;

        rst_in     = 1'b1;
        en_in      = 1'b0;
        wr_en_in   = 1'b0;
        wr_addr_in = '0;
        wr_rgb_in  = '0;
        @(negedge clk_in);

        // Reset with en high, after dirtying the palette
        wr_pal(2'd0, 24'hABCDEF);
        wr_pal(2'd2, 24'h123456);
        rst_in = 1'b0;
        en_in  = 1'b1;
        repeat (2) @(negedge clk_in);
        check_eq("rst_r", r_out, 0);
        check_eq("rst_g", g_out, 0);
        check_eq("rst_b", b_out, 0);
        check_eq("rst_idx", idx_out, 0);
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_wrap", wrap_out, 0);
        check_eq("rst_state", state_out, S_IDLE);
        rst_in = 1'b1;
        n_wrap = 0;
        wrap_k = -1;
        for (int k = 0; k < 34; k++) begin
            @(negedge clk_in);
            check_eq("rst_pal_rgb", {r_out, g_out, b_out}, 0);
            if (wrap_out) begin
                n_wrap++;
                wrap_k = k;
            end
        end
        check_eq("rst_loop_wraps", n_wrap, 1);
        check_eq("rst_loop_wrap_cycle", wrap_k, 32);
        check_eq("rst_loop_idx", idx_out, 0);

        // Single fade toward 0x030100
        do_reset();
        wr_pal(2'd0, 24'h030100);
        for (int k = 0; k <= 12; k++) exp_q.push_back((k >= 6) ? 8'd3 : 8'(k / 2));
        en_in = 1'b1;
        for (int k = 0; k <= 12; k++) begin
            @(negedge clk_in);
            check_eq("fade_r", r_out, exp_q.pop_front());
            check_eq("fade_g", g_out, (k >= 2) ? 1 : 0);
            check_eq("fade_idx", idx_out, (k >= 12) ? 1 : 0);
            check_eq("fade_state", state_out, (k < 6 || k == 12) ? S_FADE : S_HOLD);
            check_eq("fade_busy", busy_out, 1);
        end

        // Loop and wrap with alternating blue targets
        do_reset();
        wr_pal(2'd0, 24'h000005);
        wr_pal(2'd2, 24'h000005);
        wrap_q.push_back(64);
        wrap_q.push_back(128);
        en_in = 1'b1;
        for (int k = 0; k < 130; k++) begin
            @(negedge clk_in);
            if (wrap_out) check_eq("wrap_cycle", k, (wrap_q.size() > 0) ? wrap_q.pop_front() : -1);
            if (k == 10) check_eq("loop_b_up", b_out, 5);
            if (k == 18) check_eq("loop_b_down1", b_out, 4);
            if (k == 26) check_eq("loop_b_down", b_out, 0);
            if (k == 42) check_eq("loop_b_up2", b_out, 5);
            if (k == 63) check_eq("loop_idx3", idx_out, 3);
            if (k == 64) check_eq("loop_idx0", idx_out, 0);
        end
        check_eq("wrap_missing", wrap_q.size(), 0);

        // Disable mid-fade then resume
        do_reset();
        wr_pal(2'd0, 24'hFF0000);
        en_in = 1'b1;
        repeat (21) @(negedge clk_in);
        check_eq("dis_r_before", r_out, 10);
        en_in = 1'b0;
        @(negedge clk_in);
        check_eq("dis_r", r_out, 10);
        check_eq("dis_busy", busy_out, 0);
        check_eq("dis_state", state_out, S_IDLE);
        repeat (3) @(negedge clk_in);
        check_eq("dis_r_held", r_out, 10);
        en_in = 1'b1;
        @(negedge clk_in);
        check_eq("reen_busy", busy_out, 1);
        check_eq("reen_r0", r_out, 10);
        @(negedge clk_in);
        check_eq("reen_r1", r_out, 10);
        @(negedge clk_in);
        check_eq("reen_r2", r_out, 11);

        // Retarget during fade: 200 -> 30 at r=50
        do_reset();
        wr_pal(2'd0, 24'hC80000);
        en_in = 1'b1;
        repeat (101) @(negedge clk_in);
        check_eq("rt_r50", r_out, 50);
        wr_pal(2'd0, 24'h1E0000);
        check_eq("rt_r50_hold", r_out, 50);
        @(negedge clk_in);
        check_eq("rt_r49", r_out, 49);
        repeat (37) @(negedge clk_in);
        check_eq("rt_r31", r_out, 31);
        check_eq("rt_state_fade", state_out, S_FADE);
        @(negedge clk_in);
        check_eq("rt_r30", r_out, 30);
        check_eq("rt_state_hold", state_out, S_HOLD);

        // Reset while holding palette entry 2
        do_reset();
        wr_pal(2'd2, 24'h010101);
        wr_pal(2'd3, 24'h020202);
        en_in = 1'b1;
        repeat (21) @(negedge clk_in);
        check_eq("mh_state", state_out, S_HOLD);
        check_eq("mh_idx", idx_out, 2);
        check_eq("mh_rgb", {r_out, g_out, b_out}, 24'h010101);
        rst_in = 1'b0;
        @(negedge clk_in);
        check_eq("mh_rst_rgb", {r_out, g_out, b_out}, 0);
        check_eq("mh_rst_idx", idx_out, 0);
        check_eq("mh_rst_state", state_out, S_IDLE);
        check_eq("mh_rst_busy", busy_out, 0);
        check_eq("mh_rst_wrap", wrap_out, 0);
        rst_in  = 1'b1;
        nonzero = 0;
        for (int k = 0; k < 70; k++) begin
            @(negedge clk_in);
            if ({r_out, g_out, b_out} != 24'h0) nonzero++;
        end
        check_eq("mh_pal_cleared", nonzero, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
